// File: rtl/mmc5_pkg.sv
// Shared constants for the MMC5 scanline detector: nametable prefix,
// default timing windows and the repeated-read match target.
package mmc5_pkg;

   localparam logic [1:0] NT_PREFIX    = 2'b10;
   localparam int         IDLE_CYC_DEF = 128;
   localparam int         SPR_LO_DEF   = 128;
   localparam int         SPR_HI_DEF   = 160;
   localparam logic [1:0] MATCH_TGT    = 2'd2;

endpackage

// File: rtl/mmc5_edge_sync.sv
// Two-flop synchronizer for an active-low PPU strobe plus a falling-edge
// detector; fall is high for exactly one clk per synchronized 1->0 transition.
module mmc5_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic strb_n,
   output logic fall
);

   logic sync1_r;
   logic sync2_r;
   logic prev_r;

   // Synchronizer stages and one history bit; idle level of the strobe is 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
      end else begin
         sync1_r <= strb_n;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   assign fall = prev_r & ~sync2_r;

endmodule

// File: rtl/mmc5_scanline.sv
// MMC5 scanline detector: watches PPU reads for three identical nametable
// fetches, tracks the scanline number, raises the scanline IRQ and sprite window.
module mmc5_scanline
   import mmc5_pkg::*;
#(
   parameter int IDLE_CYC = IDLE_CYC_DEF,
   parameter int SPR_LO   = SPR_LO_DEF,
   parameter int SPR_HI   = SPR_HI_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] ppu_addr,
   input  logic        ppu_oe,
   input  logic        bgr_on,
   input  logic [7:0]  irq_cmp,
   input  logic        irq_en,
   input  logic        stat_rd,
   output logic        in_frame,
   output logic        irq_pend,
   output logic        irq,
   output logic [7:0]  line_cnt,
   output logic        sprt_fetch,
   output logic        line_stb
);

   localparam int IW = $clog2(IDLE_CYC + 1);

   logic          rd_s;
   logic          frame_end_s;
   logic          nt_hit_s;
   logic          line_evt_s;
   logic          irq_set_s;
   logic [7:0]    next_line_s;
   logic          in_frame_r;
   logic          irq_pend_r;
   logic [7:0]    line_cnt_r;
   logic          sprt_fetch_r;
   logic          line_stb_r;
   logic [1:0]    match_cnt_r;
   logic [7:0]    rd_cnt_r;
   logic [IW-1:0] idle_cnt_r;
   logic [13:0]   last_addr_r;

   mmc5_edge_sync u_oe_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .strb_n (ppu_oe),
      .fall   (rd_s)
   );

   // Event decode; a frame end masks any scanline event in the same clk.
   always_comb begin
      frame_end_s = (idle_cnt_r == IW'(IDLE_CYC)) || !bgr_on;
      nt_hit_s    = rd_s && (ppu_addr == last_addr_r) && (ppu_addr[13:12] == NT_PREFIX);
      line_evt_s  = nt_hit_s && (match_cnt_r == (MATCH_TGT - 2'd1)) && !frame_end_s;
      if (in_frame_r) begin
         next_line_s = line_cnt_r + 8'd1;
      end else begin
         next_line_s = 8'd0;
      end
      irq_set_s = line_evt_s && in_frame_r && (next_line_s == irq_cmp) && (irq_cmp != 8'd0);
   end

   // Frame, line, match and read-count state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_frame_r   <= 1'b0;
         irq_pend_r   <= 1'b0;
         line_cnt_r   <= 8'd0;
         sprt_fetch_r <= 1'b0;
         line_stb_r   <= 1'b0;
         match_cnt_r  <= 2'd0;
         rd_cnt_r     <= 8'd0;
         idle_cnt_r   <= '0;
         last_addr_r  <= 14'd0;
      end else begin
         line_stb_r   <= line_evt_s;
         sprt_fetch_r <= in_frame_r && (int'(rd_cnt_r) >= SPR_LO) && (int'(rd_cnt_r) < SPR_HI);

         if (rd_s) begin
            last_addr_r <= ppu_addr;
            idle_cnt_r  <= '0;
         end else if (idle_cnt_r != IW'(IDLE_CYC)) begin
            idle_cnt_r  <= idle_cnt_r + IW'(1);
         end

         if (frame_end_s) begin
            in_frame_r  <= 1'b0;
            match_cnt_r <= 2'd0;
            rd_cnt_r    <= 8'd0;
         end else if (line_evt_s) begin
            in_frame_r  <= 1'b1;
            line_cnt_r  <= next_line_s;
            match_cnt_r <= 2'd0;
            rd_cnt_r    <= 8'd0;
         end else if (rd_s) begin
            if (nt_hit_s) begin
               match_cnt_r <= (match_cnt_r == MATCH_TGT) ? MATCH_TGT : match_cnt_r + 2'd1;
            end else begin
               match_cnt_r <= 2'd0;
            end
            if (rd_cnt_r != 8'hFF) begin
               rd_cnt_r <= rd_cnt_r + 8'd1;
            end
         end

         // A set beats a coincident status-read clear.
         if (irq_set_s) begin
            irq_pend_r <= 1'b1;
         end else if (line_evt_s && !in_frame_r) begin
            irq_pend_r <= 1'b0;
         end else if (stat_rd) begin
            irq_pend_r <= 1'b0;
         end
      end
   end

   assign in_frame   = in_frame_r;
   assign irq_pend   = irq_pend_r;
   assign irq        = irq_pend_r & irq_en;
   assign line_cnt   = line_cnt_r;
   assign sprt_fetch = sprt_fetch_r;
   assign line_stb   = line_stb_r;

endmodule

// File: tb/tb_mmc5_scanline.sv
// Directed bench for mmc5_scanline: PPU read sequences with hand-computed
// expectations for frame, line, IRQ, sprite window, idle and reset behaviour.
module tb_mmc5_scanline;

   logic        clk;
   logic        rst_n;
   logic [13:0] ppu_addr;
   logic        ppu_oe;
   logic        bgr_on;
   logic [7:0]  irq_cmp;
   logic        irq_en;
   logic        stat_rd;
   logic        in_frame;
   logic        irq_pend;
   logic        irq;
   logic [7:0]  line_cnt;
   logic        sprt_fetch;
   logic        line_stb;

   int n_checks;
   int n_fail;
   int stb_cnt;

   mmc5_scanline dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ppu_addr   (ppu_addr),
      .ppu_oe     (ppu_oe),
      .bgr_on     (bgr_on),
      .irq_cmp    (irq_cmp),
      .irq_en     (irq_en),
      .stat_rd    (stat_rd),
      .in_frame   (in_frame),
      .irq_pend   (irq_pend),
      .irq        (irq),
      .line_cnt   (line_cnt),
      .sprt_fetch (sprt_fetch),
      .line_stb   (line_stb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count line_stb pulses, sampled away from the active edge.
   always @(negedge clk) begin
      if (line_stb) stb_cnt = stb_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One PPU read: strobe low for 3 clk; the rd event lands on the 3rd edge.
   task automatic ppu_read(input logic [13:0] a, input logic pulse_stat);
      @(negedge clk);
      ppu_addr = a;
      ppu_oe   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (pulse_stat) stat_rd = 1'b1;
      @(negedge clk);
      stat_rd = 1'b0;
      ppu_oe  = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic scanline_seq(input logic stat_on_last);
      ppu_read(14'h1000, 1'b0);
      ppu_read(14'h2000, 1'b0);
      ppu_read(14'h2000, 1'b0);
      ppu_read(14'h2000, stat_on_last);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      stb_cnt  = 0;
      rst_n    = 1'b0;
      ppu_addr = 14'd0;
      ppu_oe   = 1'b1;
      bgr_on   = 1'b1;
      irq_cmp  = 8'd0;
      irq_en   = 1'b0;
      stat_rd  = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_in_frame", {31'd0, in_frame}, 32'd0);
      check_eq("rst_irq_pend", {31'd0, irq_pend}, 32'd0);
      check_eq("rst_line_cnt", {24'd0, line_cnt}, 32'd0);
      check_eq("rst_sprt", {31'd0, sprt_fetch}, 32'd0);
      check_eq("rst_line_stb", {31'd0, line_stb}, 32'd0);
      rst_n   = 1'b1;
      stb_cnt = 0;

      // First scanline from reset
      ppu_read(14'h2000, 1'b0);
      ppu_read(14'h2000, 1'b0);
      ppu_read(14'h2000, 1'b0);
      check_eq("first_in_frame", {31'd0, in_frame}, 32'd1);
      check_eq("first_line_cnt", {24'd0, line_cnt}, 32'd0);
      check_eq("first_stb_cnt", stb_cnt, 32'd1);

      // Non-nametable triple and broken nametable triple give no event
      for (int i = 0; i < 3; i++) ppu_read(14'h0000, 1'b0);
      check_eq("pt_triple_stb", stb_cnt, 32'd1);
      ppu_read(14'h23C0, 1'b0);
      ppu_read(14'h23C0, 1'b0);
      ppu_read(14'h2400, 1'b0);
      check_eq("broken_stb", stb_cnt, 32'd1);
      check_eq("broken_match", {30'd0, dut.match_cnt_r}, 32'd0);
      check_eq("broken_line", {24'd0, line_cnt}, 32'd0);

      // IRQ on line 3
      irq_cmp = 8'd3;
      scanline_seq(1'b0);
      scanline_seq(1'b0);
      check_eq("line2_cnt", {24'd0, line_cnt}, 32'd2);
      check_eq("line2_pend", {31'd0, irq_pend}, 32'd0);
      scanline_seq(1'b0);
      check_eq("line3_cnt", {24'd0, line_cnt}, 32'd3);
      check_eq("line3_pend", {31'd0, irq_pend}, 32'd1);
      check_eq("line3_irq_dis", {31'd0, irq}, 32'd0);
      irq_en = 1'b1;
      #1;
      check_eq("line3_irq_en", {31'd0, irq}, 32'd1);
      @(negedge clk);
      stat_rd = 1'b1;
      @(negedge clk);
      stat_rd = 1'b0;
      check_eq("stat_clr_pend", {31'd0, irq_pend}, 32'd0);
      check_eq("stat_clr_irq", {31'd0, irq}, 32'd0);

      // Status read coincident with a set: set wins
      irq_cmp = 8'd4;
      scanline_seq(1'b1);
      check_eq("coinc_line", {24'd0, line_cnt}, 32'd4);
      check_eq("coinc_pend", {31'd0, irq_pend}, 32'd1);

      // Sprite-fetch window over 170 distinct reads
      scanline_seq(1'b0);
      check_eq("spr_line", {24'd0, line_cnt}, 32'd5);
      for (int k = 1; k <= 170; k++) begin
         ppu_read(14'h1000 + 14'(k), 1'b0);
         check_eq($sformatf("spr_rd%0d", k), {31'd0, sprt_fetch},
                  {31'd0, (k >= 128 && k < 160) ? 1'b1 : 1'b0});
      end

      // Idle timeout ends the frame, line and pend held
      repeat (140) @(negedge clk);
      check_eq("idle_in_frame", {31'd0, in_frame}, 32'd0);
      check_eq("idle_line", {24'd0, line_cnt}, 32'd5);
      check_eq("idle_pend", {31'd0, irq_pend}, 32'd1);
      check_eq("idle_sprt", {31'd0, sprt_fetch}, 32'd0);
      scanline_seq(1'b0);
      check_eq("restart_in_frame", {31'd0, in_frame}, 32'd1);
      check_eq("restart_line", {24'd0, line_cnt}, 32'd0);
      check_eq("restart_pend", {31'd0, irq_pend}, 32'd0);

      // Rendering disable ends the frame
      @(negedge clk);
      bgr_on = 1'b0;
      @(negedge clk);
      bgr_on = 1'b1;
      @(negedge clk);
      check_eq("bgr_off_frame", {31'd0, in_frame}, 32'd0);
      check_eq("bgr_off_line", {24'd0, line_cnt}, 32'd0);

      // Mid-line reset discards a partial match
      scanline_seq(1'b0);
      scanline_seq(1'b0);
      check_eq("pre_rst_line", {24'd0, line_cnt}, 32'd1);
      ppu_read(14'h1000, 1'b0);
      ppu_read(14'h2000, 1'b0);
      ppu_read(14'h2000, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("mid_rst_frame", {31'd0, in_frame}, 32'd0);
      check_eq("mid_rst_line", {24'd0, line_cnt}, 32'd0);
      check_eq("mid_rst_pend", {31'd0, irq_pend}, 32'd0);
      check_eq("mid_rst_stb", {31'd0, line_stb}, 32'd0);
      check_eq("mid_rst_match", {30'd0, dut.match_cnt_r}, 32'd0);
      stb_cnt = 0;
      ppu_read(14'h2000, 1'b0);
      check_eq("post_rst_noevt", stb_cnt, 32'd0);
      ppu_read(14'h2000, 1'b0);
      ppu_read(14'h2000, 1'b0);
      check_eq("post_rst_evt", stb_cnt, 32'd1);
      check_eq("post_rst_frame", {31'd0, in_frame}, 32'd1);

      // Line counter wrap with irq_cmp = 0 never sets pend
      irq_cmp = 8'd0;
      for (int n = 0; n < 255; n++) scanline_seq(1'b0);
      check_eq("wrap_255", {24'd0, line_cnt}, 32'd255);
      scanline_seq(1'b0);
      check_eq("wrap_0", {24'd0, line_cnt}, 32'd0);
      check_eq("wrap_pend", {31'd0, irq_pend}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mmc5_scanline.md
MMC5_SCANLINE -- requirements
Module: mmc5_scanline

Interface
REQ-001 SHALL have parameter IDLE_CYC, default 128: clk cycles with no PPU read before the frame is declared ended.
REQ-002 SHALL have parameter SPR_LO, default 128: first read index of the sprite-fetch window.
REQ-003 SHALL have parameter SPR_HI, default 160: read index one past the last read of the sprite-fetch window.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 ppu_addr  input  14  PPU address bus (asynchronous to clk).
REQ-007 ppu_oe  input  1  PPU read strobe, active-low (asynchronous to clk).
REQ-008 bgr_on  input  1  rendering enable ($2001 bit 3 shadow).
REQ-009 irq_cmp  input  8  scanline compare value ($5203).
REQ-010 irq_en  input  1  IRQ enable ($5204 bit 7).
REQ-011 stat_rd  input  1  one-clk pulse on CPU read of $5204.
REQ-012 in_frame  output  1  rendering-in-progress flag.
REQ-013 irq_pend  output  1  scanline-IRQ pending flag.
REQ-014 irq  output  1  irq_pend AND irq_en.
REQ-015 line_cnt  output  8  current scanline number.
REQ-016 sprt_fetch  output  1  high while the PPU fetches sprite patterns.
REQ-017 line_stb  output  1  one-clk pulse per detected scanline.

Function
REQ-018 SHALL pass ppu_oe through a 2-flop synchronizer; a read event (rd) SHALL be the clk where the synced value goes 1->0.
REQ-019 On rd, SHALL capture ppu_addr into cur_addr; the previous capture SHALL be held in last_addr.
REQ-020 On rd, match_cnt SHALL increment (saturating at 2) when the new address equals last_addr and addr[13:12]=2'b10; otherwise it SHALL clear to 0.
REQ-021 A scanline event SHALL occur on the rd that takes match_cnt from 1 to 2 (third identical nametable read); match_cnt SHALL then clear to 0.
REQ-022 On a scanline event with in_frame=0: in_frame<=1, line_cnt<=0, irq_pend<=0.
REQ-023 On a scanline event with in_frame=1: line_cnt<=line_cnt+1, wrapping 255->0; irq_pend<=1 when the new line_cnt equals irq_cmp and irq_cmp is nonzero.
REQ-024 line_stb SHALL pulse one clk after every scanline event.
REQ-025 rd_cnt (8 bit) SHALL clear on a scanline event, increment on every other rd, and saturate at 255.
REQ-026 sprt_fetch SHALL be registered, and SHALL equal in_frame AND SPR_LO <= rd_cnt < SPR_HI.
REQ-027 idle_cnt SHALL clear on rd and otherwise increment, saturating at IDLE_CYC.
REQ-028 When idle_cnt reaches IDLE_CYC, or when bgr_on=0: in_frame<=0, match_cnt<=0, rd_cnt<=0. line_cnt and irq_pend SHALL hold.
REQ-029 stat_rd SHALL clear irq_pend; if it coincides with a set condition, the set SHALL win.
REQ-030 A frame-end condition (REQ-028) SHALL take priority over a scanline event in the same clk.
REQ-031 All outputs SHALL be registered except irq, which is combinational.

Reset
REQ-032 With rst_n=0 at a clk edge: in_frame=0, irq_pend=0, line_cnt=0, sprt_fetch=0, line_stb=0, match_cnt=0, rd_cnt=0, idle_cnt=0, last_addr=0, and both synchronizer stages=1.
REQ-033 Reset asserted mid-line SHALL discard any partial match; detection SHALL restart from a fresh read sequence.

Structure
REQ-034 A shared package mmc5_pkg SHALL hold NT_PREFIX (2'b10), the IDLE_CYC/SPR_LO/SPR_HI defaults, and the match target (2).
REQ-035 The synchronizer and falling-edge detector SHALL be one sub-module, mmc5_edge_sync, reused for any other PPU strobe.
REQ-036 The mapper top SHALL instantiate this block and consume in_frame, irq, irq_pend, sprt_fetch and line_stb.

Verification
REQ-037 Reads $2000,$2000,$2000 with bgr_on=1 from reset -> in_frame=1, line_cnt=0, line_stb one pulse.
REQ-038 irq_cmp=3, four scanline sequences -> irq_pend rises on the 4th event (line_cnt=3); irq=1 only if irq_en=1; stat_rd -> irq_pend=0 next clk.
REQ-039 Reads $0000 x3 -> no event; $23C0,$23C0,$2400 -> no event, match_cnt=0.
REQ-040 After an event, 170 distinct reads -> sprt_fetch high exactly for rd_cnt 128..159 (32 reads).
REQ-041 No ppu_oe activity for 128 clk -> in_frame=0, line_cnt held; the next triple read -> line_cnt=0, irq_pend=0.
REQ-042 stat_rd coincident with the line_cnt==irq_cmp event -> irq_pend=1; rst_n=0 for one clk mid-line -> all outputs at their reset values.
